// File: rtl/rf_arb_pkg.sv
// Shared types, sizes and the round-robin pick function for the
// register-file write-port arbiter.
package rf_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Search starts just after ptr. The 3-bit sum wraps modulo 8 by itself.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [IDX_W-1:0] idx;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request/grant bundle between the pipeline requesters and the write-port arbiter.
interface rf_write_arbiter_if;
  import rf_arb_pkg::*;

  logic             enable;
  logic [N_REQ-1:0] req;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_onehot;
  logic             preempt;

  modport master (
    output enable, req,
    input  gnt_valid, gnt_idx, gnt_onehot, preempt
  );

  modport slave (
    input  enable, req,
    output gnt_valid, gnt_idx, gnt_onehot, preempt
  );
endinterface

// File: rtl/decoder3_8.sv
// 3-to-8 decoder with enable; produces the register-file write-enable lines.
module decoder3_8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);

  // One-hot decode, all lines low while disabled
  always_comb begin
    y = 8'h00;
    if (en) begin
      y = 8'h01 << a;
    end else begin
      y = 8'h00;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a bounded
// hold time so one requester cannot starve the rest.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  rf_write_arbiter_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_BUSY = 1'(BUSY);

  logic [0:0]       state_r,     state_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic [IDX_W-1:0] gnt_idx_r,   gnt_idx_s;
  logic [IDX_W-1:0] ptr_r,       ptr_s;
  logic [HOLD_W-1:0] hold_r,     hold_s;
  logic             preempt_r,   preempt_s;
  logic [N_REQ-1:0] others_s;
  pick_t            pick_req_s;
  pick_t            pick_oth_s;

  // Candidates: everyone for a fresh grant, everyone except the holder otherwise
  always_comb begin
    others_s   = bus.req & ~(N_REQ'(1) << gnt_idx_r);
    pick_req_s = rr_pick(bus.req, ptr_r);
    pick_oth_s = rr_pick(others_s, ptr_r);
  end

  // Next-state and next-grant decision
  always_comb begin
    state_s     = state_r;
    gnt_valid_s = gnt_valid_r;
    gnt_idx_s   = gnt_idx_r;
    ptr_s       = ptr_r;
    hold_s      = hold_r;
    preempt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.enable && pick_req_s.found) begin
          state_s     = ST_BUSY;
          gnt_valid_s = 1'b1;
          gnt_idx_s   = pick_req_s.idx;
          ptr_s       = pick_req_s.idx;
          hold_s      = HOLD_ONE;
        end else begin
          state_s     = ST_IDLE;
          gnt_valid_s = 1'b0;
          gnt_idx_s   = '0;
        end
      end
      ST_BUSY: begin
        if (!bus.req[gnt_idx_r]) begin
          if (bus.enable && pick_oth_s.found) begin
            gnt_idx_s = pick_oth_s.idx;
            ptr_s     = pick_oth_s.idx;
            hold_s    = HOLD_ONE;
          end else begin
            state_s     = ST_IDLE;
            gnt_valid_s = 1'b0;
            gnt_idx_s   = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_r == HOLD_MAX) &&
                     bus.enable && pick_oth_s.found) begin
          gnt_idx_s = pick_oth_s.idx;
          ptr_s     = pick_oth_s.idx;
          hold_s    = HOLD_ONE;
          preempt_s = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_r != HOLD_MAX)) begin
          hold_s = hold_r + HOLD_ONE;
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        hold_s      = '0;
      end
    endcase
  end

  // State and registered outputs; ptr resets to 7 so requester 0 wins first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      gnt_valid_r <= 1'b0;
      gnt_idx_r   <= '0;
      ptr_r       <= 3'd7;
      hold_r      <= '0;
      preempt_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_valid_r <= gnt_valid_s;
      gnt_idx_r   <= gnt_idx_s;
      ptr_r       <= ptr_s;
      hold_r      <= hold_s;
      preempt_r   <= preempt_s;
    end
  end

  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.preempt   = preempt_r;

  decoder3_8 u_dec (
    .en (gnt_valid_r),
    .a  (gnt_idx_r),
    .y  (bus.gnt_onehot)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench: each driven cycle queues its expected grant, a monitor
// compares after the following clock edge.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic       v;
    logic [2:0] i;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    logic [7:0] oh;
    oh = e.v ? (8'h01 << e.i) : 8'h00;
    vectors++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !== {e.v, e.i, oh, e.p}) begin
      miscompares++;
      $display("FAIL %s t=%0t: got valid=%0b idx=%0d onehot=%02h preempt=%0b, want valid=%0b idx=%0d onehot=%02h preempt=%0b",
               name, $time, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt,
               e.v, e.i, oh, e.p);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [7:0] r, input logic en,
                      input logic ev, input logic [2:0] ei, input logic ep);
    exp_t e;
    @(negedge clk);
    bus.req    = r;
    bus.enable = en;
    e.v = ev;
    e.i = ei;
    e.p = ep;
    exp_q.push_back(e);
  endtask

  // Monitor: compare queued expectations just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", e);
      end
    end
  end

  initial begin
    exp_t zero;
    zero = '0;
    reset_n    = 1'b0;
    bus.req    = 8'h00;
    bus.enable = 1'b0;
    #1;
    check("reset_state", zero);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single request, one-cycle latency, release to idle
    step(8'h10, 1'b1, 1'b1, 3'd4, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Hold limit: 0 for 4 cycles, preempt to 1 for 4, back to 0
    step(8'h03, 1'b1, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) step(8'h03, 1'b1, 1'b1, 3'd0, 1'b0);
    step(8'h03, 1'b1, 1'b1, 3'd1, 1'b1);
    for (int k = 0; k < 3; k++) step(8'h03, 1'b1, 1'b1, 3'd1, 1'b0);
    step(8'h03, 1'b1, 1'b1, 3'd0, 1'b1);
    // Alone, requester 0 keeps the port with no preempt
    for (int k = 0; k < 7; k++) step(8'h01, 1'b1, 1'b1, 3'd0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Wrap and pointer
    step(8'h80, 1'b1, 1'b1, 3'd7, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    step(8'h81, 1'b1, 1'b1, 3'd0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    step(8'h81, 1'b1, 1'b1, 3'd7, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Rotation: each holder drops for one cycle, grants 0..7,0 with no bubble
    step(8'hFF, 1'b1, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] r;
      r = ~(8'h01 << k);
      step(r, 1'b1, 1'b1, 3'((k + 1) % 8), 1'b0);
    end
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Enable gating: 2 holds past the limit, 5 waits for enable
    step(8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
    for (int k = 0; k < 6; k++) step(8'h24, 1'b0, 1'b1, 3'd2, 1'b0);
    step(8'h20, 1'b0, 1'b0, 3'd0, 1'b0);
    step(8'h20, 1'b0, 1'b0, 3'd0, 1'b0);
    step(8'h20, 1'b1, 1'b1, 3'd5, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Reset mid-grant, then requester 6 again one cycle after release
    step(8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
    step(8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    bus.req = 8'h00;
    #1;
    check("async_reset", zero);
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
    step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
